// File: rtl/design_25.sv
// Registered W-bit adder with a one-cycle start/valid handshake.
// Each accepted start yields valid for exactly the following cycle.
module design_25 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         valid
);

  // Carry out is intentionally dropped: result wraps mod 2^W.
  logic [W-1:0] sum;

  assign sum = a + b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= start;
      if (start) begin
        y <= sum;
      end
    end
  end

endmodule

// File: tb/tb_design_25.sv
// Scoreboard bench for design_25: sums queued at start, checked at valid.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_design_25;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] y;
  logic         valid;

  int vectors;
  int miscompares;

  logic [W-1:0] q[$];
  logic [W-1:0] m_y;
  logic         m_v;
  logic [W-1:0] exp_y;

  design_25 #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .y    (y),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; the model updates from the inputs seen at the edge.
  task automatic tick();
    logic [W-1:0] s;
    @(posedge clk);
    s = a + b;
    if (rst_n && start) begin
      q.push_back(s);
      m_y = s;
      m_v = 1'b1;
    end else if (rst_n) begin
      m_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_y = '0;
    m_v = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    a = 8'd5;
    b = 8'd7;
    model_reset();
    #1;
    vectors++;
    if (valid !== 1'b0 || y !== '0) begin
      miscompares++;
      $display("FAIL reset_async got valid=%0b y=%0d want 0/0", valid, y);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (valid !== 1'b0 || y !== '0) begin
        miscompares++;
        $display("FAIL reset_hold%0d got valid=%0b y=%0d want 0/0", i, valid, y);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    vectors++;
    if (valid !== 1'b0 || y !== '0) begin
      miscompares++;
      $display("FAIL reset_release got valid=%0b y=%0d want 0/0", valid, y);
    end
  endtask

  task automatic test_single();
    a = 8'd3;
    b = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_y = q.size() > 0 ? q.pop_front() : 'x;
    vectors++;
    if (valid !== 1'b1 || y !== exp_y || y !== 8'd8) begin
      miscompares++;
      $display("FAIL single got valid=%0b y=%0d want 1/%0d", valid, y, exp_y);
    end
    tick();
    vectors++;
    if (valid !== 1'b0 || y !== m_y) begin
      miscompares++;
      $display("FAIL single_hold got valid=%0b y=%0d want 0/%0d", valid, y, m_y);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] oa[2];
    logic [W-1:0] ob[2];
    logic [W-1:0] lit[2];
    oa = '{8'd200, 8'd255};
    ob = '{8'd100, 8'd1};
    lit = '{8'd44, 8'd0};
    for (int i = 0; i < 2; i++) begin
      a = oa[i];
      b = ob[i];
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_y = q.size() > 0 ? q.pop_front() : 'x;
      vectors++;
      if (valid !== 1'b1 || y !== exp_y || y !== lit[i]) begin
        miscompares++;
        $display("FAIL overflow%0d got valid=%0b y=%0d want 1/%0d", i, valid, y, lit[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ba[3];
    logic [W-1:0] bb[3];
    logic [W-1:0] lit[3];
    ba = '{8'd1, 8'd10, 8'd128};
    bb = '{8'd2, 8'd20, 8'd128};
    lit = '{8'd3, 8'd30, 8'd0};
    for (int i = 0; i < 3; i++) begin
      a = ba[i];
      b = bb[i];
      start = 1'b1;
      tick();
      exp_y = q.size() > 0 ? q.pop_front() : 'x;
      vectors++;
      if (valid !== 1'b1 || y !== exp_y || y !== lit[i]) begin
        miscompares++;
        $display("FAIL b2b%0d got valid=%0b y=%0d want 1/%0d", i, valid, y, lit[i]);
      end
    end
    start = 1'b0;
    tick();
    vectors++;
    if (valid !== 1'b0 || y !== m_y) begin
      miscompares++;
      $display("FAIL b2b_end got valid=%0b y=%0d want 0/%0d", valid, y, m_y);
    end
  endtask

  task automatic test_mid_reset();
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_y = q.size() > 0 ? q.pop_front() : 'x;
    vectors++;
    if (valid !== 1'b1 || y !== exp_y) begin
      miscompares++;
      $display("FAIL midrst_pre got valid=%0b y=%0d want 1/%0d", valid, y, exp_y);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (valid !== 1'b0 || y !== '0) begin
      miscompares++;
      $display("FAIL midrst_async got valid=%0b y=%0d want 0/0", valid, y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (valid !== 1'b0 || y !== '0) begin
      miscompares++;
      $display("FAIL midrst_release got valid=%0b y=%0d want 0/0", valid, y);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rand%0d scoreboard empty got y=%0d", i, y);
      end else begin
        exp_y = q.pop_front();
        vectors++;
        if (valid !== 1'b1 || y !== exp_y) begin
          miscompares++;
          $display("FAIL rand%0d got valid=%0b y=%0d want 1/%0d", i, valid, y, exp_y);
        end
      end
      for (int k = 0; k < 3; k++) begin
        tick();
        vectors++;
        if (valid !== 1'b0 || y !== m_y) begin
          miscompares++;
          $display("FAIL rand%0d_idle%0d got valid=%0b y=%0d want 0/%0d", i, k, valid, y, m_y);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    model_reset();
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/design_25.md
Name: design_25

Overview:
Single-stage registered adder with a one-cycle start/valid handshake. Each `start` pulse captures `a + b` (truncated to W bits) into an output register. `valid` is asserted for exactly the cycle after each accepted start. Used as a small pipelined datapath leaf; there is no backpressure.

Parameters:
- W, 8, operand and result width in bits (W >= 1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled every rising clk edge
- a  input  W  operand A, sampled with start
- b  input  W  operand B, sampled with start
- y  output  W  registered sum
- valid  output  1  high for one cycle per accepted start; y is meaningful while high

Behaviour:
- Reset, rst_n = 0:
  - Asynchronous: y = 0 and valid = 0 immediately, without waiting for a clock edge.
  - Both outputs stay 0 for as long as rst_n is low.
  - The start, a and b inputs are ignored while rst_n is low.
- Reset release: the first rising edge with rst_n = 1 is an ordinary operating edge, and start is honoured on it.
- Rising edge with start = 1:
  - y <= (a + b) mod 2^W; the carry out is discarded.
  - valid <= 1.
- Rising edge with start = 0:
  - valid <= 0.
  - y holds its previous value.
- Latency is exactly 1 cycle: start sampled at edge N gives valid = 1 and y = sum of the a/b sampled at edge N, during the cycle after edge N.
- Back-to-back starts:
  - valid stays high continuously.
  - y updates every cycle to the sum of the operands sampled on the preceding edge.
  - No starts are dropped; the block accepts one start per cycle.
- Invariant: whenever valid = 1, y equals the W-bit sum of the a and b sampled on the most recent edge at which start = 1.
- Overflow: no saturation and no carry/overflow flag. Examples for W = 8:
  - 255 + 1 = 0
  - 200 + 100 = 44
- Reset mid-operation: asserting rst_n while valid = 1 drops valid and clears y asynchronously. A start sampled on the same edge that reset is asserted is lost.
- No X propagation: y and valid are always driven from registers. There is no combinational path from the inputs to the outputs.
- Unused states: none. The control is a single valid flop; there is no FSM beyond idle/valid.

Test Plan:
- Reset check: hold rst_n = 0 for 3 cycles with start = 1, a = 5, b = 7 -> valid = 0 and y = 0 throughout. After release, with start = 0 -> valid stays 0.
- Single transaction: a = 3, b = 5, start pulsed for one cycle -> on the next cycle valid = 1 and y = 8; one cycle later valid = 0 and y still 8.
- Overflow wrap (W = 8): a = 200, b = 100 with start -> next cycle y = 44, valid = 1. Also a = 255, b = 1 -> y = 0, valid = 1.
- Back-to-back: start high for 3 consecutive cycles with (1,2), (10,20), (128,128) -> valid high for 3 consecutive cycles with y = 3, 30, 0, then valid = 0.
- Mid-operation reset: start with a = 9, b = 9, then assert rst_n low asynchronously (between edges) while valid = 1 -> y = 0 and valid = 0 immediately. After release with no start -> valid stays 0.
- Randomized regression: 10 random (a, b) pairs, each start followed by 3 idle cycles -> every valid cycle matches a scoreboard holding the W-bit sum captured on start, and every start produces valid on the following cycle.
